// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the clk_div_gen divider.
//   CNT_W_DEF   : default width of the divisor and the phase counter
//   MIN_DIV_DEF : default smallest legal divide ratio
//   clamp_div() : raises a requested ratio to at least the minimum
//   half_div()  : duty threshold; CLK_OUT is high while cnt < half_div(N)
package clk_div_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int MIN_DIV_DEF = 2;

  function automatic int unsigned clamp_div(input int unsigned x, input int unsigned min_div);
    return (x < min_div) ? min_div : x;
  endfunction

  function automatic int unsigned half_div(input int unsigned n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/clk_div_gen.sv
// clk_div_gen: runtime-programmable integer clock divider.
// Produces a registered divided clock CLK_OUT plus a one-cycle TICK that is
// high in the CLK_IN cycle where CLK_OUT starts a period. Ratio updates are
// staged in a pending register and only take effect on a period wrap, so
// CLK_OUT never glitches.
//
// Ports:
//   CLK_IN     in   source clock
//   RESET      in   asynchronous, active-high reset
//   ENABLE     in   1 = run, 0 = freeze counter / CLK_OUT / DIV_ACTIVE
//   SYNC       in   (only with CLK_DIV_SYNC_EN) force a period restart
//   DIV_IN     in   requested divide ratio
//   DIV_LOAD   in   one-cycle strobe capturing DIV_IN
//   DIV_ACK    out  one-cycle pulse when a new ratio becomes active
//   DIV_ACTIVE out  ratio currently in force
//   CLK_OUT    out  divided clock (high floor(N/2), low ceil(N/2) cycles)
//   TICK       out  first-cycle-of-period pulse
//
// Build option: define CLK_DIV_SYNC_EN to add the SYNC input for phase
// alignment to an external event (e.g. VSYNC).
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 2,
  parameter int MIN_DIV     = MIN_DIV_DEF
) (
  input  logic             CLK_IN,
  input  logic             RESET,
  input  logic             ENABLE,
`ifdef CLK_DIV_SYNC_EN
  input  logic             SYNC,
`endif
  input  logic [CNT_W-1:0] DIV_IN,
  input  logic             DIV_LOAD,
  output logic             DIV_ACK,
  output logic [CNT_W-1:0] DIV_ACTIVE,
  output logic             CLK_OUT,
  output logic             TICK
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_active_q, div_active_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;

  logic             sync_req;
  logic             wrap;
  logic             apply;
  logic [CNT_W-1:0] n_new;

`ifdef CLK_DIV_SYNC_EN
  assign sync_req = SYNC;
`else
  assign sync_req = 1'b0;
`endif

  always_comb begin
    cnt_d        = cnt_q;
    div_active_d = div_active_q;
    pend_div_d   = pend_div_q;
    pend_vld_d   = pend_vld_q;
    clk_out_d    = clk_out_q;
    tick_d       = 1'b0;
    ack_d        = 1'b0;

    // SYNC behaves exactly like a natural wrap, including pending apply.
    wrap  = (cnt_q == div_active_q - CNT_W'(1)) | sync_req;
    apply = ENABLE & wrap & pend_vld_q;
    // Ratio governing the period that starts (or continues) after this edge.
    n_new = apply ? pend_div_q : div_active_q;

    if (ENABLE) begin
      cnt_d        = wrap ? '0 : cnt_q + CNT_W'(1);
      div_active_d = n_new;
      clk_out_d    = (32'(cnt_d) < half_div(32'(n_new)));
      tick_d       = (cnt_d == '0);
      ack_d        = apply;
    end

    if (apply) pend_vld_d = 1'b0;

    // A load on the applying edge lands after the apply, so it survives
    // as the next pending value instead of being swallowed.
    if (DIV_LOAD) begin
      pend_div_d = CNT_W'(clamp_div(32'(DIV_IN), 32'(MIN_DIV)));
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      cnt_q        <= CNT_W'(DEFAULT_DIV - 1);
      div_active_q <= CNT_W'(DEFAULT_DIV);
      pend_div_q   <= CNT_W'(DEFAULT_DIV);
      pend_vld_q   <= 1'b0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      div_active_q <= div_active_d;
      pend_div_q   <= pend_div_d;
      pend_vld_q   <= pend_vld_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
      ack_q        <= ack_d;
    end
  end

  assign DIV_ACK    = ack_q;
  assign DIV_ACTIVE = div_active_q;
  assign CLK_OUT    = clk_out_q;
  assign TICK       = tick_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen. A behavioural model predicts each edge's
// outputs; predictions are queued when inputs are driven and popped once
// the DUT has clocked. Extra directed checks pin waveform shapes.
module tb_clk_div_gen;

  logic       CLK_IN = 1'b0;
  logic       RESET;
  logic       ENABLE;
  logic [7:0] DIV_IN;
  logic       DIV_LOAD;
  logic       sync;
  logic       DIV_ACK;
  logic [7:0] DIV_ACTIVE;
  logic       CLK_OUT;
  logic       TICK;

  always #5 CLK_IN = ~CLK_IN;

  clk_div_gen dut (
    .CLK_IN    (CLK_IN),
    .RESET     (RESET),
    .ENABLE    (ENABLE),
`ifdef CLK_DIV_SYNC_EN
    .SYNC      (sync),
`endif
    .DIV_IN    (DIV_IN),
    .DIV_LOAD  (DIV_LOAD),
    .DIV_ACK   (DIV_ACK),
    .DIV_ACTIVE(DIV_ACTIVE),
    .CLK_OUT   (CLK_OUT),
    .TICK      (TICK)
  );

  typedef struct {
    int clk;
    int tick;
    int ack;
    int div;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  // model state
  int m_cnt, m_div, m_pd, m_pv, m_clk, m_tick, m_ack;

  // observation helpers
  int          ack_seen;
  int          tick_seen;
  int          seen7;
  logic [15:0] hist;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_cnt = 1; m_div = 2; m_pd = 2; m_pv = 0;
    m_clk = 0; m_tick = 0; m_ack = 0;
  endtask

  task automatic model_edge(input int en, input int ld, input int din, input int sy);
    int wr;
    int ap;
    if (en != 0) begin
      wr = ((m_cnt == m_div - 1) || (sy != 0)) ? 1 : 0;
      ap = (wr != 0 && m_pv != 0) ? 1 : 0;
      if (ap != 0) begin
        m_div = m_pd;
        m_pv  = 0;
      end
      m_cnt  = (wr != 0) ? 0 : m_cnt + 1;
      m_clk  = (m_cnt < m_div / 2) ? 1 : 0;
      m_tick = (m_cnt == 0) ? 1 : 0;
      m_ack  = ap;
    end else begin
      m_tick = 0;
      m_ack  = 0;
    end
    if (ld != 0) begin
      m_pd = (din < 2) ? 2 : din;
      m_pv = 1;
    end
  endtask

  // Drive one cycle of inputs, predict, clock, then compare.
  task automatic step(input logic en, input logic ld, input logic [7:0] din, input logic sy);
    exp_t e;
    ENABLE = en; DIV_LOAD = ld; DIV_IN = din; sync = sy;
`ifdef CLK_DIV_SYNC_EN
    model_edge(int'(en), int'(ld), int'(din), int'(sy));
`else
    model_edge(int'(en), int'(ld), int'(din), 0);
`endif
    exp_q.push_back('{clk: m_clk, tick: m_tick, ack: m_ack, div: m_div});
    @(posedge CLK_IN);
    #1;
    e = exp_q.pop_front();
    chk("clk_out",    32'(CLK_OUT),    32'(e.clk));
    chk("tick",       32'(TICK),       32'(e.tick));
    chk("div_ack",    32'(DIV_ACK),    32'(e.ack));
    chk("div_active", 32'(DIV_ACTIVE), 32'(e.div));
    if (DIV_ACK === 1'b1) ack_seen++;
    if (TICK === 1'b1) tick_seen++;
    if (DIV_ACTIVE === 8'd7) seen7++;
    hist = {hist[14:0], CLK_OUT};
    DIV_LOAD = 1'b0;
    sync = 1'b0;
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    while (DIV_ACK !== 1'b1 && n < 20) begin
      step(1'b1, 1'b0, 8'd0, 1'b0);
      n++;
    end
    if (DIV_ACK !== 1'b1) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_and_wait(input logic [7:0] d);
    step(1'b1, 1'b1, d, 1'b0);
    wait_ack();
  endtask

  initial begin
    RESET = 1'b1; ENABLE = 1'b1; DIV_IN = '0; DIV_LOAD = 1'b0; sync = 1'b0;
    hist = '0; ack_seen = 0; tick_seen = 0; seen7 = 0;
    model_reset();
    @(posedge CLK_IN); @(posedge CLK_IN); #1;

    // reset state
    chk("rst_clk_out", 32'(CLK_OUT),    32'd0);
    chk("rst_tick",    32'(TICK),       32'd0);
    chk("rst_ack",     32'(DIV_ACK),    32'd0);
    chk("rst_div",     32'(DIV_ACTIVE), 32'd2);
    RESET = 1'b0;

    // default N=2: first edge rises with TICK, then toggles every edge
    step(1'b1, 1'b0, 8'd0, 1'b0);
    chk("first_rise_clk",  32'(CLK_OUT), 32'd1);
    chk("first_rise_tick", 32'(TICK),    32'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'd0, 1'b0);
    chk("n2_pattern", 32'(hist[5:0]), 32'(6'b101010));

    // N=5 loaded mid-stream: one ack, then 2 high / 3 low, TICK every 5
    ack_seen = 0;
    load_and_wait(8'd5);
    hist = 16'(CLK_OUT);
    tick_seen = 1;
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'd0, 1'b0);
    chk("n5_pattern", 32'(hist[9:0]), 32'(10'b1100011000));
    chk("n5_ticks",   32'(tick_seen), 32'd2);
    chk("n5_one_ack", 32'(ack_seen),  32'd1);

    // 0 and 1 clamp to MIN_DIV
    load_and_wait(8'd0);
    chk("clamp0_div", 32'(DIV_ACTIVE), 32'd2);
    load_and_wait(8'd1);
    chk("clamp1_div", 32'(DIV_ACTIVE), 32'd2);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd0, 1'b0);
    chk("clamp_not_stuck", 32'(hist[3:0]), 32'(4'b1010));

    // two loads within one period: 7 then 4, single ack, 7 never active
    load_and_wait(8'd6);
    ack_seen = 0; seen7 = 0;
    step(1'b1, 1'b1, 8'd7, 1'b0);
    step(1'b1, 1'b1, 8'd4, 1'b0);
    wait_ack();
    chk("dbl_div", 32'(DIV_ACTIVE), 32'd4);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'd0, 1'b0);
    chk("dbl_one_ack", 32'(ack_seen), 32'd1);
    chk("dbl_no7",     32'(seen7),    32'd0);

    // freeze for 10 cycles with N=4 at cnt=1; a load during freeze is kept
    step(1'b1, 1'b0, 8'd0, 1'b0);
    tick_seen = 0; ack_seen = 0;
    for (int i = 0; i < 10; i++) step(1'b0, (i == 4) ? 1'b1 : 1'b0, 8'd3, 1'b0);
    chk("frz_clk",   32'(hist[9:0]), 32'(10'h3ff));
    chk("frz_ticks", 32'(tick_seen), 32'd0);
    step(1'b1, 1'b0, 8'd0, 1'b0);
    chk("resume_clk",  32'(CLK_OUT), 32'd0);
    chk("resume_tick", 32'(TICK),    32'd0);
    wait_ack();
    chk("frz_load_div", 32'(DIV_ACTIVE), 32'd3);

    // async reset with N=6 and a pending load
    load_and_wait(8'd6);
    step(1'b1, 1'b1, 8'd9, 1'b0);
    step(1'b1, 1'b0, 8'd0, 1'b0);
    #3 RESET = 1'b1;
    #1;
    chk("arst_clk_out", 32'(CLK_OUT),    32'd0);
    chk("arst_tick",    32'(TICK),       32'd0);
    chk("arst_ack",     32'(DIV_ACK),    32'd0);
    chk("arst_div",     32'(DIV_ACTIVE), 32'd2);
    model_reset();
    @(posedge CLK_IN); #1;
    RESET = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'd0, 1'b0);
    chk("arst_no_ack",   32'(ack_seen),   32'd0);
    chk("arst_div_hold", 32'(DIV_ACTIVE), 32'd2);

`ifdef CLK_DIV_SYNC_EN
    // SYNC at cnt=2 with N=6 restarts the period
    load_and_wait(8'd6);
    step(1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 8'd0, 1'b1);
    chk("sync_tick", 32'(TICK),    32'd1);
    chk("sync_clk",  32'(CLK_OUT), 32'd1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'd0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
